// File: rtl/bjt_uart_pkg.sv
// Shared definitions for the host-to-board UART command receiver.
// Holds the default sync marker, both FSM encodings, packet field
// positions and the bit-period helper.
package bjt_uart_pkg;

  // Packet start marker used when the top level is not overridden
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Byte positions inside a 5-byte command packet
  localparam int PKT_SYNC = 0;
  localparam int PKT_ADDR = 1;
  localparam int PKT_DH   = 2;
  localparam int PKT_DL   = 3;
  localparam int PKT_CHK  = 4;

  // Serial byte framing states
  typedef enum logic [2:0] {
    BS_IDLE,
    BS_START,
    BS_DATA,
    BS_STOP,
    BS_BREAK
  } byte_state_e;

  // Packet assembly states; each encoding equals the index of the byte it waits for
  typedef enum logic [2:0] {
    PS_HUNT = 3'(PKT_SYNC),
    PS_ADDR = 3'(PKT_ADDR),
    PS_DH   = 3'(PKT_DH),
    PS_DL   = 3'(PKT_DL),
    PS_CHK  = 3'(PKT_CHK)
  } pkt_state_e;

  // Clocks per serial bit, truncated
  function automatic int calc_bit_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte deserialiser with 2-flop input synchroniser.
// Latency: rx_valid_o one cycle after the mid-stop-bit sample (~9.5 bits + 3 clocks after start edge).
// Backpressure: none; rx_valid_o/frame_err_o are unconditional single-cycle strobes.
module uart_rx_byte
  import bjt_uart_pkg::*;
#(
  parameter int BIT_CNT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(BIT_CNT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BIT_CNT);
  localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CNT / 2);

  logic          sync1_q, rx_s_q, rx_prev_q;
  byte_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          fall, tick;

  // Synchronise the asynchronous line; idle-high preset so reset never looks like a start edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_i;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall = rx_prev_q & ~rx_s_q;
  // Counter is reloaded on every expiry, so it lands on 1 exactly at each sample point
  assign tick = (cnt_q <= CW'(1));

  // Framing FSM: next state, sample point timing and shift register
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      BS_IDLE: begin
        if (fall) begin
          cnt_d   = CNT_HALF;
          state_d = BS_START;
        end
      end
      BS_START: begin
        if (tick) begin
          if (!rx_s_q) begin
            cnt_d     = CNT_FULL;
            bit_idx_d = 3'd0;
            state_d   = BS_DATA;
          end else begin
            state_d   = BS_IDLE;
          end
        end
      end
      BS_DATA: begin
        if (tick) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = CNT_FULL;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = BS_STOP;
          end
        end
      end
      BS_STOP: begin
        if (tick) begin
          if (rx_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = BS_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BS_BREAK;
          end
        end
      end
      BS_BREAK: begin
        if (rx_s_q) begin
          state_d = BS_IDLE;
        end
      end
      default: state_d = BS_IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BS_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: assembles SYNC/ADDR/DH/DL/CHK packets into command strobes.
// Latency: cmd_valid/chk_err one cycle after the CHK byte's rx_valid.
// Backpressure: none; all strobes are unconditional, the host paces the line.
module uart_cmd_rx
  import bjt_uart_pkg::*;
#(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         BAUD         = 115200,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic        globalclock,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic        chk_err,
  output logic        busy
);

  localparam int BIT_CNT = calc_bit_cnt(CLK_FREQ, BAUD);
  localparam int TMO_CYC = TIMEOUT_BITS * BIT_CNT;
  localparam int TW      = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  logic [7:0]  byte_dat;
  logic        byte_vld;
  logic        byte_ferr;

  pkt_state_e  pstate_q, pstate_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  dh_q, dh_d;
  logic [7:0]  dl_q, dl_d;
  logic [7:0]  cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_data_q, cmd_data_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        chk_err_q, chk_err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  uart_rx_byte #(
    .BIT_CNT (BIT_CNT)
  ) u_byte (
    .clk_i       (globalclock),
    .rst_ni      (rst),
    .rx_i        (uart_rx),
    .rx_data_o   (byte_dat),
    .rx_valid_o  (byte_vld),
    .frame_err_o (byte_ferr)
  );

  // Packet FSM: byte staging, checksum compare and inter-byte timeout
  always_comb begin
    pstate_d    = pstate_q;
    addr_d      = addr_q;
    dh_d        = dh_q;
    dl_d        = dl_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = 1'b0;
    chk_err_d   = 1'b0;
    tmo_d       = tmo_q;
    if (byte_vld) begin
      // A byte arriving in the expiry cycle takes priority over the timeout
      tmo_d = '0;
      unique case (pstate_q)
        PS_HUNT: if (byte_dat == SYNC_BYTE) pstate_d = PS_ADDR;
        PS_ADDR: begin
          addr_d   = byte_dat;
          pstate_d = PS_DH;
        end
        PS_DH: begin
          dh_d     = byte_dat;
          pstate_d = PS_DL;
        end
        PS_DL: begin
          dl_d     = byte_dat;
          pstate_d = PS_CHK;
        end
        PS_CHK: begin
          if (byte_dat == (addr_q ^ dh_q ^ dl_q)) begin
            cmd_addr_d  = addr_q;
            cmd_data_d  = {dh_q, dl_q};
            cmd_valid_d = 1'b1;
          end else begin
            chk_err_d   = 1'b1;
          end
          pstate_d = PS_HUNT;
        end
        default: pstate_d = PS_HUNT;
      endcase
    end else if (byte_ferr) begin
      pstate_d = PS_HUNT;
      tmo_d    = '0;
    end else if (pstate_q != PS_HUNT) begin
      if (tmo_q >= TMO_LAST) begin
        pstate_d = PS_HUNT;
        tmo_d    = '0;
      end else begin
        tmo_d    = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Packet state, staging and command output registers
  always_ff @(posedge globalclock or negedge rst) begin
    if (!rst) begin
      pstate_q    <= PS_HUNT;
      addr_q      <= 8'h00;
      dh_q        <= 8'h00;
      dl_q        <= 8'h00;
      cmd_addr_q  <= 8'h00;
      cmd_data_q  <= 16'h0000;
      cmd_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      pstate_q    <= pstate_d;
      addr_q      <= addr_d;
      dh_q        <= dh_d;
      dl_q        <= dl_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      chk_err_q   <= chk_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign rx_data   = byte_dat;
  assign rx_valid  = byte_vld;
  assign frame_err = byte_ferr;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_valid = cmd_valid_q;
  assign chk_err   = chk_err_q;
  assign busy      = (pstate_q != PS_HUNT);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: directed scenarios plus randomized packet streams.
// Expected bytes/commands come from a packet-level model fed as each byte is sent.
// A negedge monitor pops and compares whenever the DUT strobes.
module tb_uart_cmd_rx;

  localparam int         CLK_FREQ     = 50_000_000;
  localparam int         BAUD         = 2_500_000;
  localparam int         BIT          = CLK_FREQ / BAUD;
  localparam int         TIMEOUT_BITS = 20;
  localparam logic [7:0] SYNC         = 8'hA5;

  logic        globalclock = 1'b0;
  logic        rst         = 1'b0;
  logic        uart_rx     = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        frame_err;
  logic        chk_err;
  logic        busy;

  uart_cmd_rx #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .SYNC_BYTE    (SYNC),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .globalclock (globalclock),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .frame_err   (frame_err),
    .chk_err     (chk_err),
    .busy        (busy)
  );

  always #10 globalclock = ~globalclock;

  // Scoreboard state
  logic [7:0]  exp_rx[$];
  logic [23:0] exp_cmd[$];
  logic [23:0] exp_chk[$];
  logic [7:0]  pkt[$];
  logic [23:0] last_cmd = 24'h0;
  int exp_ferr = 0, obs_ferr = 0, exp_rx_total = 0, obs_rx = 0, pend_idle = 0;
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: strobe with value %0h, none expected", name, act);
  endtask

  // Packet-level reference: any byte stream, timeout judged from the idle gap before the byte
  task automatic model_byte(input logic [7:0] b, input int gap_bits);
    if (pkt.size() != 0 && gap_bits + 10 > TIMEOUT_BITS) pkt.delete();
    exp_rx.push_back(b);
    exp_rx_total++;
    if (pkt.size() != 0 || b == SYNC) pkt.push_back(b);
    if (pkt.size() == 5) begin
      if ((pkt[1] ^ pkt[2] ^ pkt[3]) == pkt[4]) begin
        last_cmd = {pkt[1], pkt[2], pkt[3]};
        exp_cmd.push_back(last_cmd);
      end else begin
        exp_chk.push_back(last_cmd);
      end
      pkt.delete();
    end
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * BIT) @(negedge globalclock);
    pend_idle += n;
  endtask

  // gap idle bits, then start, 8 data LSB first, stop (low stop held for 1+hold bits)
  task automatic send_byte(input logic [7:0] b, input int gap, input bit stop_ok, input int hold);
    int g;
    g = gap + pend_idle;
    pend_idle = 0;
    uart_rx = 1'b1;
    repeat (gap * BIT) @(negedge globalclock);
    if (stop_ok) model_byte(b, g);
    else begin
      pkt.delete();
      exp_ferr++;
    end
    uart_rx = 1'b0;
    repeat (BIT) @(negedge globalclock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge globalclock);
    end
    uart_rx = stop_ok;
    repeat ((stop_ok ? 1 : 1 + hold) * BIT) @(negedge globalclock);
    uart_rx = 1'b1;
  endtask

  task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4);
    send_byte(b0, 0, 1'b1, 0);
    send_byte(b1, 0, 1'b1, 0);
    send_byte(b2, 0, 1'b1, 0);
    send_byte(b3, 0, 1'b1, 0);
    send_byte(b4, 0, 1'b1, 0);
  endtask

  // Random gap avoids the timeout boundary: short (<=3 bits) or clearly expired (>=14 bits)
  task automatic send_rand(input logic [7:0] b);
    int gap;
    bit ferr;
    gap  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 22)) : int'($urandom_range(0, 3));
    ferr = ($urandom_range(0, 19) == 0);
    send_byte(b, gap, !ferr, 0);
    if (ferr) idle_bits(2);
  endtask

  function automatic logic [7:0] rand_data();
    return ($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom_range(0, 255));
  endfunction

  task automatic check_all_zero(input string name);
    check(name, {27'h0, rx_data, rx_valid, cmd_addr, cmd_data, cmd_valid, frame_err, chk_err, busy}, 64'h0);
  endtask

  // Monitor: compare every strobe against the scoreboard queues
  always @(negedge globalclock) begin
    if (rx_valid) begin
      obs_rx++;
      if (exp_rx.size() == 0) unexpected("rx_unexpected", 64'(rx_data));
      else check("rx_data", 64'(rx_data), 64'(exp_rx.pop_front()));
    end
    if (cmd_valid) begin
      if (exp_cmd.size() == 0) unexpected("cmd_unexpected", 64'({cmd_addr, cmd_data}));
      else check("cmd", 64'({cmd_addr, cmd_data}), 64'(exp_cmd.pop_front()));
    end
    if (chk_err) begin
      if (exp_chk.size() == 0) unexpected("chk_err_unexpected", 64'({cmd_addr, cmd_data}));
      else check("cmd_hold_on_chk_err", 64'({cmd_addr, cmd_data}), 64'(exp_chk.pop_front()));
    end
    if (frame_err) obs_ferr++;
  end

  // Bound on total run length
  initial begin
    repeat (95000) @(posedge globalclock);
    $display("FAIL watchdog: run did not complete within cycle budget");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, h, l, c;
    // Reset state
    repeat (3) @(negedge globalclock);
    check_all_zero("reset_outputs");
    rst = 1'b1;
    idle_bits(2);

    // Good packet 01/1234, busy through the packet
    send_byte(SYNC, 0, 1'b1, 0);
    check("busy_after_sync", 64'(busy), 64'd1);
    send_byte(8'h01, 0, 1'b1, 0);
    send_byte(8'h12, 0, 1'b1, 0);
    send_byte(8'h34, 0, 1'b1, 0);
    send_byte(8'h27, 0, 1'b1, 0);
    check("cmd_p1", 64'({cmd_addr, cmd_data}), 64'h011234);
    check("busy_after_p1", 64'(busy), 64'd0);

    // Bad checksum: cmd outputs hold
    send_seq(SYNC, 8'h02, 8'hAB, 8'hCD, 8'h00);
    check("cmd_hold_p2", 64'({cmd_addr, cmd_data}), 64'h011234);
    check("chk_err_seen", 64'(exp_chk.size()), 64'd0);

    // Short low glitch on idle line: no strobes
    uart_rx = 1'b0;
    repeat (BIT / 4) @(negedge globalclock);
    uart_rx = 1'b1;
    idle_bits(3);
    check("glitch_rx_count", 64'(obs_rx), 64'(exp_rx_total));
    check("glitch_ferr_count", 64'(obs_ferr), 64'(exp_ferr));

    // Bad stop bit then held-low line: exactly one frame_err, then recovery
    send_byte(8'h55, 0, 1'b0, 30);
    check("ferr_once", 64'(obs_ferr), 64'(exp_ferr));
    check("ferr_no_rx", 64'(obs_rx), 64'(exp_rx_total));
    idle_bits(2);
    send_byte(8'hC3, 0, 1'b1, 0);
    check("rx_after_break", 64'(rx_data), 64'hC3);

    // Inter-byte timeout drops the packet
    send_byte(SYNC, 0, 1'b1, 0);
    send_byte(8'h03, 0, 1'b1, 0);
    check("busy_before_timeout", 64'(busy), 64'd1);
    idle_bits(25);
    check("busy_after_timeout", 64'(busy), 64'd0);
    send_byte(8'h00, 0, 1'b1, 0);
    send_byte(8'h10, 0, 1'b1, 0);
    send_byte(8'h13, 0, 1'b1, 0);
    check("cmd_hold_timeout", 64'({cmd_addr, cmd_data}), 64'h011234);
    send_seq(SYNC, 8'h03, 8'h00, 8'h10, 8'h13);
    check("cmd_p3", 64'({cmd_addr, cmd_data}), 64'h030010);

    // Asynchronous reset mid-DATA of the second packet byte
    send_byte(SYNC, 0, 1'b1, 0);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge globalclock);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'b1;
      repeat (BIT) @(negedge globalclock);
    end
    #3 rst = 1'b0;
    #1 check_all_zero("reset_mid_byte");
    pkt.delete();
    last_cmd  = 24'h0;
    pend_idle = 0;
    repeat (3) @(negedge globalclock);
    uart_rx = 1'b1;
    rst     = 1'b1;
    idle_bits(2);
    send_seq(SYNC, 8'h04, 8'h00, 8'hFF, 8'hFB);
    check("cmd_p4", 64'({cmd_addr, cmd_data}), 64'h0400FF);

    // Randomized packet stream: noise, sync-in-data, bad checksums, timeouts, frame errors
    for (int p = 0; p < 25; p++) begin
      if ($urandom_range(0, 3) == 0) send_rand(8'($urandom_range(0, 255)));
      a = rand_data();
      h = rand_data();
      l = rand_data();
      c = a ^ h ^ l;
      if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
      send_rand(SYNC);
      send_rand(a);
      send_rand(h);
      send_rand(l);
      send_rand(c);
    end
    idle_bits(2);

    check("rx_drained", 64'(exp_rx.size()), 64'd0);
    check("cmd_drained", 64'(exp_cmd.size()), 64'd0);
    check("chk_drained", 64'(exp_chk.size()), 64'd0);
    check("ferr_total", 64'(obs_ferr), 64'(exp_ferr));
    check("rx_total", 64'(obs_rx), 64'(exp_rx_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
